// File: rtl/fsm_host_ctrl_pkg.sv
// Shared types and constants for the host-side sequencer of the 16-bit-bus float engine.
package fsm_host_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_DP,
        LOAD,
        WAIT_LOW,
        COLLECT,
        FINISH
    } state_t;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_ERR01   = 3'd1;
    localparam logic [2:0] ST_ERR10   = 3'd2;
    localparam logic [2:0] ST_ERR11   = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_OVF     = 3'd5;

    // Half-words streamed to the engine per command: a_hi, a_lo, b_hi, b_lo
    localparam int ENG_WORDS = 4;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } res_entry_t;

    function automatic logic [15:0] op_word(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] idx);
        case (idx)
            2'd0:    return a[31:16];
            2'd1:    return a[15:0];
            2'd2:    return b[31:16];
            default: return b[15:0];
        endcase
    endfunction

    function automatic logic [2:0] err_code(input logic [1:0] err);
        case (err)
            2'b01:   return ST_ERR01;
            2'b10:   return ST_ERR10;
            default: return ST_ERR11;
        endcase
    endfunction

endpackage

// File: rtl/fsm_host_ctrl_res_fifo.sv
// Result FIFO holding {last,data}; mark_last retro-tags the newest stored entry on an abort.
module res_fifo
    import fsm_host_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  res_entry_t push_data,
    input  logic       pop,
    input  logic       mark_last,
    output res_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    res_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   tail_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
    assign do_push  = push && (!full || do_pop);
    assign tail_ptr = wr_ptr - AW'(1);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (mark_last && !empty)
                mem[tail_ptr].last <= 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsm_host_ctrl.sv
// Host sequencer: resets the engine, streams one operand pair, gathers results into a FIFO,
// and reports how the command ended (count reached, engine error, timeout, overflow).
module fsm_host_ctrl
    import fsm_host_ctrl_pkg::*;
#(
    parameter int MAX_RESULTS = 8,
    parameter int TIMEOUT     = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_last,
    output logic        done,
    output logic [2:0]  status,
    output logic [15:0] dp_data_in,
    output logic        dp_r_i,
    output logic        dp_reset,
    input  logic        dp_r_o,
    input  logic [1:0]  dp_err,
    input  logic [31:0] dp_data_out
);

    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [1:0]      word_idx;
    logic [7:0]      res_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            r_o_q;

    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    res_entry_t      push_entry;
    res_entry_t      head;

    logic            active;
    logic            strobe;
    logic            err_abort;
    logic            ovf_abort;
    logic            tmo_abort;
    logic            abort;
    logic            last_res;

    always_comb begin
        active     = (state == LOAD) || (state == WAIT_LOW) || (state == COLLECT);
        strobe     = (state == COLLECT) && dp_r_o && !r_o_q;
        pop        = !fifo_empty && res_ready;
        err_abort  = active && (dp_err != 2'b00);
        ovf_abort  = strobe && fifo_full && !pop;
        // A result arriving on the deadline cycle rescues the command
        tmo_abort  = active && !strobe && (tmo_cnt == TW'(TIMEOUT - 1));
        abort      = err_abort || ovf_abort || tmo_abort;
        push       = strobe && !err_abort && !ovf_abort;
        last_res   = ((res_cnt + 8'd1) == 8'(MAX_RESULTS));
        push_entry.last = last_res;
        push_entry.data = dp_data_out;
    end

    assign cmd_ready = (state == IDLE) && fifo_empty;
    assign res_valid = !fifo_empty;
    assign res_data  = head.data;
    assign res_last  = head.last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            word_idx   <= '0;
            res_cnt    <= '0;
            tmo_cnt    <= '0;
            r_o_q      <= 1'b0;
            done       <= 1'b0;
            status     <= ST_OK;
            dp_r_i     <= 1'b0;
            dp_data_in <= '0;
            dp_reset   <= 1'b1;
        end else begin
            r_o_q <= dp_r_o;
            done  <= 1'b0;
            if (active) tmo_cnt <= tmo_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    dp_reset <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        a_q      <= cmd_a;
                        b_q      <= cmd_b;
                        res_cnt  <= '0;
                        word_idx <= '0;
                        tmo_cnt  <= '0;
                        state    <= RST_DP;
                    end
                end
                // Two cycles of engine reset bring it to its load state
                RST_DP: begin
                    if (word_idx[0]) begin
                        word_idx   <= '0;
                        dp_reset   <= 1'b0;
                        dp_r_i     <= 1'b1;
                        dp_data_in <= op_word(a_q, b_q, 2'd0);
                        state      <= LOAD;
                    end else begin
                        word_idx <= 2'd1;
                    end
                end
                LOAD: begin
                    if (word_idx == 2'(ENG_WORDS - 1)) begin
                        dp_r_i     <= 1'b0;
                        dp_data_in <= '0;
                        tmo_cnt    <= '0;
                        state      <= WAIT_LOW;
                    end else begin
                        word_idx   <= word_idx + 2'd1;
                        dp_data_in <= op_word(a_q, b_q, word_idx + 2'd1);
                    end
                end
                WAIT_LOW: begin
                    if (!dp_r_o) state <= COLLECT;
                end
                COLLECT: begin
                    if (strobe) tmo_cnt <= '0;
                    if (push) begin
                        res_cnt <= res_cnt + 8'd1;
                        if (last_res) begin
                            state    <= FINISH;
                            done     <= 1'b1;
                            status   <= ST_OK;
                            dp_reset <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (abort) begin
                state      <= FINISH;
                done       <= 1'b1;
                dp_reset   <= 1'b1;
                dp_r_i     <= 1'b0;
                dp_data_in <= '0;
                status     <= err_abort ? err_code(dp_err) : (ovf_abort ? ST_OVF : ST_TIMEOUT);
            end
        end
    end

    res_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .mark_last(abort),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_fsm_host_ctrl.sv
// Directed bench for fsm_host_ctrl: the bench plays the engine and the result consumer.
module tb_fsm_host_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic        done;
    logic [2:0]  status;
    logic [15:0] dp_data_in;
    logic        dp_r_i;
    logic        dp_reset;
    logic        dp_r_o;
    logic [1:0]  dp_err;
    logic [31:0] dp_data_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fsm_host_ctrl #(
        .MAX_RESULTS(8),
        .TIMEOUT    (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_last   (res_last),
        .done       (done),
        .status     (status),
        .dp_data_in (dp_data_in),
        .dp_r_i     (dp_r_i),
        .dp_reset   (dp_reset),
        .dp_r_o     (dp_r_o),
        .dp_err     (dp_err),
        .dp_data_out(dp_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // One result strobe: a low cycle then a rising r_o carrying d
    task automatic strobe(input logic [31:0] d);
        dp_r_o = 1'b0;
        tick();
        dp_r_o      = 1'b1;
        dp_data_out = d;
        tick();
        dp_r_o = 1'b0;
    endtask

    task automatic run_ok(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] words, input logic [31:0] base);
        res_ready = 1'b1;
        dp_r_o    = 1'b1;
        issue(a, b);
        chk("rst_dp_reset", dp_reset, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        tick();
        chk("rst_ri_low", dp_r_i, 0);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("load_ri", dp_r_i, 1);
            chk("load_bus", dp_data_in, words[63-16*w -: 16]);
            chk("load_dp_reset", dp_reset, 0);
        end
        tick();
        chk("wait_ri_low", dp_r_i, 0);
        dp_r_o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            strobe(base + i);
            chk("ok_valid", res_valid, 1);
            chk("ok_data", res_data, base + i);
            chk("ok_last", res_last, (i == 7));
            chk("ok_done", done, (i == 7));
        end
        chk("ok_status", status, 0);
        tick();
        chk("ok_done_pulse", done, 0);
        chk("ok_idle_ready", cmd_ready, 1);
        chk("ok_drained", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        res_ready   = 1'b1;
        dp_r_o      = 1'b0;
        dp_err      = 2'b00;
        dp_data_out = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_r_i", dp_r_i, 0);
        chk("rst_data_in", dp_data_in, 0);
        chk("rst_dp_reset", dp_reset, 1);

        // Normal command
        run_ok(32'h4000_0000, 32'h4100_0000, 64'h4000_0000_4100_0000, 32'hA000_0000);

        // Engine error during load
        res_ready = 1'b1;
        dp_r_o    = 1'b1;
        issue(32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        tick();
        chk("err_in_load", dp_r_i, 1);
        dp_err = 2'b11;
        tick();
        dp_err = 2'b00;
        chk("err_done", done, 1);
        chk("err_status", status, 3);
        chk("err_dp_reset", dp_reset, 1);
        chk("err_r_i", dp_r_i, 0);
        chk("err_no_res", res_valid, 0);
        tick();
        chk("err_done_pulse", done, 0);
        chk("err_ready", cmd_ready, 1);
        chk("err_no_res2", res_valid, 0);
        chk("err_no_last", res_last, 0);

        // Overflow: consumer stalled, fifth result dropped
        res_ready = 1'b0;
        dp_r_o    = 1'b1;
        issue(32'h3F80_0000, 32'h3F80_0000);
        repeat (6) tick();
        dp_r_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(32'hB000_0000 + i);
            chk("ovf_valid", res_valid, 1);
            chk("ovf_head_stable", res_data, 32'hB000_0000);
            chk("ovf_head_last", res_last, 0);
            chk("ovf_no_done", done, 0);
        end
        strobe(32'hB000_0004);
        chk("ovf_done", done, 1);
        chk("ovf_status", status, 5);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_valid", res_valid, 1);
            chk("ovf_drain_data", res_data, 32'hB000_0000 + i);
            chk("ovf_drain_last", res_last, (i == 3));
            tick();
        end
        chk("ovf_empty", res_valid, 0);
        chk("ovf_ready", cmd_ready, 1);

        // Full FIFO, pop and strobe on the same edge
        res_ready = 1'b0;
        dp_r_o    = 1'b1;
        issue(32'h4049_0FDB, 32'h402D_F854);
        repeat (6) tick();
        dp_r_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(32'hC000_0000 + i);
            chk("sim_fill", res_valid, 1);
        end
        dp_r_o = 1'b0;
        tick();
        dp_r_o      = 1'b1;
        dp_data_out = 32'hC000_0004;
        res_ready   = 1'b1;
        tick();
        dp_r_o = 1'b0;
        chk("sim_no_ovf", done, 0);
        for (int i = 1; i < 5; i++) begin
            chk("sim_order", res_data, 32'hC000_0000 + i);
            chk("sim_last", res_last, 0);
            tick();
        end
        chk("sim_empty", res_valid, 0);
        for (int i = 5; i < 8; i++) begin
            strobe(32'hC000_0000 + i);
            chk("sim_data", res_data, 32'hC000_0000 + i);
            chk("sim_tail_last", res_last, (i == 7));
            chk("sim_done", done, (i == 7));
        end
        chk("sim_status", status, 0);
        tick();

        // Timeout: no strobe after WAIT_LOW entry
        res_ready = 1'b1;
        dp_r_o    = 1'b1;
        issue(32'h0000_0001, 32'h0000_0002);
        repeat (6) tick();
        chk("tmo_wait_low", dp_r_i, 0);
        dp_r_o = 1'b0;
        repeat (31) tick();
        chk("tmo_not_yet", done, 0);
        tick();
        chk("tmo_done", done, 1);
        chk("tmo_status", status, 4);
        chk("tmo_no_res", res_valid, 0);
        tick();
        chk("tmo_done_pulse", done, 0);
        chk("tmo_status_held", status, 4);

        // Asynchronous reset in the middle of COLLECT
        res_ready = 1'b0;
        dp_r_o    = 1'b1;
        issue(32'h5555_AAAA, 32'hAAAA_5555);
        repeat (6) tick();
        dp_r_o = 1'b0;
        strobe(32'hD000_0000);
        strobe(32'hD000_0001);
        chk("mid_has_res", res_valid, 1);
        reset = 1'b0;
        #2;
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_res_last", res_last, 0);
        chk("mid_done", done, 0);
        chk("mid_status", status, 0);
        chk("mid_r_i", dp_r_i, 0);
        chk("mid_data_in", dp_data_in, 0);
        chk("mid_dp_reset", dp_reset, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_ok(32'h3F80_0000, 32'hC000_0000, 64'h3F80_0000_C000_0000, 32'hE000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
